// File: rtl/sram_block_mover_pkg.sv
// Shared definitions for the IDCT block mover: state type, mode, segment defaults,
// and sample helpers. Optional macro WS_CLIP_EN selects saturating write-back.
package sram_block_mover_pkg;

  typedef enum logic [2:0] {
    S_MV_IDLE,
    S_MV_FS,
    S_MV_FS_FLUSH,
    S_MV_WS,
    S_MV_WS_FLUSH
  } mv_state_t;

  typedef enum logic {
    MODE_FS,
    MODE_WS
  } mv_mode_t;

  localparam logic [17:0] PRE_IDCT_BASE_DEF  = 18'd76800;
  localparam logic [17:0] OUT_BASE_DEF       = 18'd0;
  localparam logic [17:0] PRE_ROW_STRIDE_DEF = 18'd320;
  localparam logic [17:0] OUT_ROW_STRIDE_DEF = 18'd160;

  // block_row * 8 * stride built from shifted copies of the stride, mod 2^18
  function automatic logic [17:0] block_row_offset(input logic [4:0]  block_row,
                                                   input logic [17:0] stride);
    logic [17:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 5; b++) begin
      if (block_row[b]) acc = acc + (stride << (b + 3));
    end
    return acc;
  endfunction

  function automatic logic [7:0] clip_sample(input logic [31:0] s);
`ifdef WS_CLIP_EN
    if (s[31])              return 8'd0;
    else if (s[30:8] != '0) return 8'hFF;
    else                    return s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  function automatic logic [31:0] sign_extend16(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

endpackage

// File: rtl/sram_block_mover_addr_gen.sv
// SRAM address generator: row base accumulated by stride plus column offset,
// shared by fetch (8 words/row) and write-back (4 words/row).
module sram_addr_gen
  import sram_block_mover_pkg::*;
#(
  parameter logic [17:0] PRE_IDCT_BASE  = PRE_IDCT_BASE_DEF,
  parameter logic [17:0] OUT_BASE       = OUT_BASE_DEF,
  parameter logic [17:0] PRE_ROW_STRIDE = PRE_ROW_STRIDE_DEF,
  parameter logic [17:0] OUT_ROW_STRIDE = OUT_ROW_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  mv_mode_t    load_mode,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  input  logic        step,
  output logic [17:0] address
);

  mv_mode_t    mode;
  logic [17:0] row_base;
  logic [17:0] col_off;
  logic [2:0]  col;
  logic [2:0]  col_last;
  logic [17:0] stride;

  assign col_last = (mode == MODE_FS) ? 3'd7 : 3'd3;
  assign stride   = (mode == MODE_FS) ? PRE_ROW_STRIDE : OUT_ROW_STRIDE;
  assign address  = row_base + col_off + {15'd0, col};

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_FS;
      row_base <= '0;
      col_off  <= '0;
      col      <= '0;
    end else if (load) begin
      mode <= load_mode;
      col  <= '0;
      if (load_mode == MODE_FS) begin
        row_base <= PRE_IDCT_BASE + block_row_offset(block_row, PRE_ROW_STRIDE);
        col_off  <= {9'd0, block_col, 3'd0};
      end else begin
        row_base <= OUT_BASE + block_row_offset(block_row, OUT_ROW_STRIDE);
        col_off  <= {10'd0, block_col, 2'd0};
      end
    end else if (step) begin
      if (col == col_last) begin
        col      <= '0;
        row_base <= row_base + stride;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sram_block_mover.sv
// Moves one 8x8 block between SRAM and R0: fetch into R0[0..63], clipped/packed
// write-back from R0[64..127]. Optional macro WS_CLIP_EN saturates samples to [0,255].
module sram_block_mover
  import sram_block_mover_pkg::*;
#(
  parameter logic [17:0] PRE_IDCT_BASE  = PRE_IDCT_BASE_DEF,
  parameter logic [17:0] OUT_BASE       = OUT_BASE_DEF,
  parameter logic [17:0] PRE_ROW_STRIDE = PRE_ROW_STRIDE_DEF,
  parameter logic [17:0] OUT_ROW_STRIDE = OUT_ROW_STRIDE_DEF
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        FS_start,
  output logic        FS_done,
  input  logic        WS_start,
  output logic        WS_done,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  input  logic [31:0] read_data_R0 [1:0],
  output logic [31:0] write_data_R0 [1:0],
  output logic [6:0]  rw_address_R0 [1:0],
  output logic        write_enable_R0 [1:0]
);

  mv_state_t state;
  logic [6:0] cnt;
  logic       fs_we;
  logic       fs_active;
  logic       accept;
  mv_mode_t   accept_mode;

  assign fs_active   = (state == S_MV_FS) || (state == S_MV_FS_FLUSH);
  assign accept      = (state == S_MV_IDLE) && (FS_start || WS_start);
  assign accept_mode = FS_start ? MODE_FS : MODE_WS;

  sram_addr_gen #(
    .PRE_IDCT_BASE (PRE_IDCT_BASE),
    .OUT_BASE      (OUT_BASE),
    .PRE_ROW_STRIDE(PRE_ROW_STRIDE),
    .OUT_ROW_STRIDE(OUT_ROW_STRIDE)
  ) u_addr_gen (
    .clk      (CLOCK_50_I),
    .rst      (Resetn),
    .load     (accept),
    .load_mode(accept_mode),
    .block_row(block_row),
    .block_col(block_col),
    .step     ((state == S_MV_FS) || !SRAM_we_n),
    .address  (SRAM_address)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (Resetn) begin
      state            <= S_MV_IDLE;
      cnt              <= '0;
      FS_done          <= 1'b0;
      WS_done          <= 1'b0;
      SRAM_we_n        <= 1'b1;
      fs_we            <= 1'b0;
      rw_address_R0[0] <= '0;
      rw_address_R0[1] <= '0;
    end else begin
      FS_done   <= 1'b0;
      WS_done   <= 1'b0;
      SRAM_we_n <= 1'b1;
      fs_we     <= 1'b0;
      case (state)
        S_MV_IDLE: begin
          if (FS_start) begin
            state <= S_MV_FS;
            cnt   <= '0;
          end else if (WS_start) begin
            state            <= S_MV_WS;
            cnt              <= '0;
            rw_address_R0[0] <= 7'd64;
            rw_address_R0[1] <= 7'd65;
          end
        end
        S_MV_FS: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd63) state <= S_MV_FS_FLUSH;
        end
        S_MV_FS_FLUSH: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd66) begin
            state   <= S_MV_IDLE;
            FS_done <= 1'b1;
          end
        end
        S_MV_WS: begin
          SRAM_we_n <= 1'b0;
          cnt       <= cnt + 7'd1;
          if (cnt == 7'd31) begin
            state <= S_MV_WS_FLUSH;
          end else begin
            rw_address_R0[0] <= 7'd66 + {cnt[5:0], 1'b0};
            rw_address_R0[1] <= 7'd67 + {cnt[5:0], 1'b0};
          end
        end
        S_MV_WS_FLUSH: begin
          state   <= S_MV_IDLE;
          WS_done <= 1'b1;
        end
        default: state <= S_MV_IDLE;
      endcase
      // Element i's read is issued when cnt == i and its data lands three cycles
      // later, so the R0 write index is derived from cnt instead of a valid pipe.
      if (fs_active && (cnt >= 7'd2) && (cnt <= 7'd65)) begin
        fs_we            <= 1'b1;
        rw_address_R0[0] <= cnt - 7'd2;
      end
    end
  end

  assign write_enable_R0[0] = fs_we;
  assign write_enable_R0[1] = 1'b0;
  assign write_data_R0[0]   = fs_we ? sign_extend16(SRAM_read_data) : '0;
  assign write_data_R0[1]   = '0;
  assign SRAM_write_data    = SRAM_we_n ? '0
                            : {clip_sample(read_data_R0[0]), clip_sample(read_data_R0[1])};

endmodule

// File: tb/tb_sram_block_mover.sv
// Bench for sram_block_mover: SRAM/R0 memory models plus a cycle-level
// expectation process derived from the transfer timing and address formulas.
module tb_sram_block_mover;

  localparam int PRE   = 76800;
  localparam int OUTB  = 0;
  localparam int PSTR  = 320;
  localparam int OSTR  = 160;

  logic        clk;
  logic        rst;
  logic        FS_start, WS_start, FS_done, WS_done;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [31:0] read_data_R0 [1:0];
  logic [31:0] write_data_R0 [1:0];
  logic [6:0]  rw_address_R0 [1:0];
  logic        write_enable_R0 [1:0];

  logic [15:0] sram [0:262143];
  logic [31:0] r0 [0:127];
  logic [15:0] p1, p2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;
  int mbr = 0;
  int mbc = 0;

  sram_block_mover dut (
    .CLOCK_50_I     (clk),
    .Resetn         (rst),
    .FS_start       (FS_start),
    .FS_done        (FS_done),
    .WS_start       (WS_start),
    .WS_done        (WS_done),
    .block_row      (block_row),
    .block_col      (block_col),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .read_data_R0   (read_data_R0),
    .write_data_R0  (write_data_R0),
    .rw_address_R0  (rw_address_R0),
    .write_enable_R0(write_enable_R0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: read data visible three cycles after the address
  always @(posedge clk) begin
    p1 <= sram[SRAM_address];
    p2 <= p1;
    SRAM_read_data <= p2;
    if (!SRAM_we_n) sram[SRAM_address] <= SRAM_write_data;
  end

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (write_enable_R0[p]) r0[rw_address_R0[p]] <= write_data_R0[p];
      read_data_R0[p] <= r0[rw_address_R0[p]];
    end
  end

  function automatic logic [17:0] fs_addr(input int br, input int bc, input int i);
    int a;
    a = PRE + (br * 8 + i / 8) * PSTR + bc * 8 + i % 8;
    return a[17:0];
  endfunction

  function automatic logic [17:0] ws_addr(input int br, input int bc, input int k);
    int a;
    a = OUTB + (br * 8 + k / 4) * OSTR + bc * 4 + k % 4;
    return a[17:0];
  endfunction

  function automatic logic [7:0] clip8(input logic [31:0] v);
`ifdef WS_CLIP_EN
    if ($signed(v) < 0)        return 8'd0;
    else if ($signed(v) > 255) return 8'd255;
    else                       return v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle expectations, t = cycles since the start was accepted
  always @(negedge clk) begin
    int t;
    t = cyc - start_cyc;
    chk("r0_we1", {31'd0, write_enable_R0[1]}, 32'd0);
    case (mode)
      1: begin
        chk("fs_done", {31'd0, FS_done}, {31'd0, t == 68});
        chk("ws_done_in_fs", {31'd0, WS_done}, 32'd0);
        chk("we_n_in_fs", {31'd0, SRAM_we_n}, 32'd1);
        chk("fs_r0_we", {31'd0, write_enable_R0[0]}, {31'd0, t >= 4 && t <= 67});
        if (t >= 1 && t <= 64)
          chk("fs_sram_addr", {14'd0, SRAM_address}, {14'd0, fs_addr(mbr, mbc, t - 1)});
        if (t >= 4 && t <= 67) begin
          chk("fs_r0_addr", {25'd0, rw_address_R0[0]}, 32'(t - 4));
          chk("fs_r0_data", write_data_R0[0], sx(sram[fs_addr(mbr, mbc, t - 4)]));
        end
      end
      2: begin
        chk("ws_done", {31'd0, WS_done}, {31'd0, t == 34});
        chk("fs_done_in_ws", {31'd0, FS_done}, 32'd0);
        chk("r0_we0_in_ws", {31'd0, write_enable_R0[0]}, 32'd0);
        chk("ws_we_n", {31'd0, SRAM_we_n}, {31'd0, !(t >= 2 && t <= 33)});
        if (t >= 1 && t <= 32) begin
          chk("ws_r0_addr0", {25'd0, rw_address_R0[0]}, 32'(64 + 2 * (t - 1)));
          chk("ws_r0_addr1", {25'd0, rw_address_R0[1]}, 32'(65 + 2 * (t - 1)));
        end
        if (t >= 2 && t <= 33) begin
          chk("ws_sram_addr", {14'd0, SRAM_address}, {14'd0, ws_addr(mbr, mbc, t - 2)});
          chk("ws_sram_data", {16'd0, SRAM_write_data},
              {16'd0, clip8(r0[64 + 2 * (t - 2)]), clip8(r0[65 + 2 * (t - 2)])});
        end
      end
      default: begin
        chk("idle_fs_done", {31'd0, FS_done}, 32'd0);
        chk("idle_ws_done", {31'd0, WS_done}, 32'd0);
        chk("idle_we_n", {31'd0, SRAM_we_n}, 32'd1);
        chk("idle_r0_we0", {31'd0, write_enable_R0[0]}, 32'd0);
      end
    endcase
  end

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, {14'd0, SRAM_address}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, SRAM_write_data}, 32'd0);
    chk({tag, "_we_n"}, {31'd0, SRAM_we_n}, 32'd1);
    chk({tag, "_r0a0"}, {25'd0, rw_address_R0[0]}, 32'd0);
    chk({tag, "_r0a1"}, {25'd0, rw_address_R0[1]}, 32'd0);
    chk({tag, "_r0d0"}, write_data_R0[0], 32'd0);
    chk({tag, "_r0d1"}, write_data_R0[1], 32'd0);
    chk({tag, "_r0we0"}, {31'd0, write_enable_R0[0]}, 32'd0);
    chk({tag, "_dones"}, {30'd0, FS_done, WS_done}, 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a start for cycle 0, returns #1 into cycle 1 with the index inputs scrambled
  task automatic start_op(input bit fs, input bit ws, input int br, input int bc);
    FS_start  = fs;
    WS_start  = ws;
    block_row = 5'(br);
    block_col = 6'(bc);
    mbr       = br;
    mbc       = bc;
    start_cyc = cyc;
    mode      = fs ? 1 : (ws ? 2 : 0);
    tick(1);
    FS_start  = 1'b0;
    WS_start  = 1'b0;
    block_row = '1;
    block_col = '1;
  endtask

  initial begin
    for (int a = 0; a < 262144; a++) sram[a] = '0;
    for (int a = 0; a < 128; a++) r0[a] = '0;
    rst = 1'b1;
    FS_start = 1'b0;
    WS_start = 1'b0;
    block_row = '0;
    block_col = '0;
    tick(3);
    check_reset("reset");
    rst = 1'b0;
    tick(2);

    // Fetch block (0,0): coefficient value r*8+c-32
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        sram[PRE + r * PSTR + c] = 16'(r * 8 + c - 32);
    start_op(1, 0, 0, 0);
    tick(68);
    mode = 0;
    for (int i = 0; i < 64; i++) chk("fs00_r0", r0[i], 32'(i - 32));
    chk("fs00_r0_first", r0[0], 32'hFFFFFFE0);
    chk("fs00_r0_last", r0[63], 32'h0000001F);
    tick(2);

    // Fetch block (2,5): first/last address pinned by hand
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        sram[81960 + r * PSTR + c] = 16'(1000 * r - 77 * c - 300);
    start_op(1, 0, 2, 5);
    chk("fs25_first_addr", {14'd0, SRAM_address}, 32'd81960);
    tick(63);
    chk("fs25_last_addr", {14'd0, SRAM_address}, 32'd84207);
    tick(5);
    mode = 0;
    for (int i = 0; i < 64; i++) chk("fs25_r0", r0[i], sx(16'(1000 * (i / 8) - 77 * (i % 8) - 300)));
    tick(2);

    // Write-back block (1,3)
    r0[64] = 32'd10;
    r0[65] = 32'd300;
    r0[66] = 32'hFFFFFFFB;
    r0[67] = 32'd255;
    for (int i = 68; i < 128; i++) r0[i] = 32'(i * 13 - 1000);
    start_op(0, 1, 1, 3);
    tick(34);
    mode = 0;
    tick(1);
`ifdef WS_CLIP_EN
    chk("ws_sram1292", {16'd0, sram[1292]}, 32'h0AFF);
    chk("ws_sram1293", {16'd0, sram[1293]}, 32'h00FF);
`else
    chk("ws_sram1292", {16'd0, sram[1292]}, 32'h0A2C);
    chk("ws_sram1293", {16'd0, sram[1293]}, 32'hFBFF);
`endif
    for (int k = 0; k < 32; k++)
      chk("ws13_sram", {16'd0, sram[ws_addr(1, 3, k)]},
          {16'd0, clip8(r0[64 + 2 * k]), clip8(r0[65 + 2 * k])});
    tick(2);

    // Simultaneous starts: fetch only; a write-back start mid-fetch is ignored
    start_op(1, 1, 0, 0);
    tick(9);
    WS_start = 1'b1;
    tick(1);
    WS_start = 1'b0;
    tick(58);
    mode = 0;
    tick(6);

    // Write-back then fetch started the cycle after WS_done
    start_op(0, 1, 0, 1);
    tick(34);
    start_op(1, 0, 0, 0);
    tick(68);
    mode = 0;
    tick(2);

    // Reset during fetch at cycle 30
    start_op(1, 0, 0, 0);
    tick(29);
    rst = 1'b1;
    tick(1);
    mode = 0;
    check_reset("mid_reset");
    tick(1);
    rst = 1'b0;
    tick(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
